serial_word_receiver: RTL and testbench
=======================================

# serial_word_receiver

Serial-to-parallel receiver paired with `parametrized_shift_register` in serial-out mode. It accepts one bit per qualified clock on `shiftin`, aligns words on a start marker, and assembles `SHIFT_WIDTH` bits into a parallel word. Completed words are presented on `q` with a valid/ready handshake. It sits at the receiving end of the serial link, in front of the word-level consumer.

## Interface
Parameters:
- `SHIFT_WIDTH`, default 8: data bits per word; must be at least 2.
- `SHIFT_DIRECTION`, default "LEFT": bit order of the link.
  - "LEFT": MSB-first; the first bit lands in `q[SHIFT_WIDTH-1]`.
  - "RIGHT": LSB-first; the first bit lands in `q[0]`.

Ports:
- `clock`  in  1  single clock; all logic is on the rising edge.
- `sclr`  in  1  reset, synchronous and active-high.
- `enable`  in  1  bit-acceptance gate.
- `sin_valid`  in  1  `shiftin` carries a bit this cycle.
- `sin_first`  in  1  the current bit is bit 0 of a word (alignment marker).
- `shiftin`  in  1  serial data bit.
- `q`  out  SHIFT_WIDTH  received word.
- `q_valid`  out  1  `q` holds an unconsumed word.
- `q_ready`  in  1  consumer accepts `q`.
- `q_perr`  out  1  parity error flag for the word on `q`.
- `overflow`  out  1  sticky: a completed word was dropped.
- `busy`  out  1  a word is partially received.

## Operation
- A bit is accepted when `enable && sin_valid`. No other input condition accepts a bit.
- States:
  - IDLE: an accepted bit with `sin_first=1` loads bit 0, sets count to 1 and moves to SHIFT. An accepted bit with `sin_first=0` is discarded.
  - SHIFT: each accepted bit is shifted in and the count increments.
    - "LEFT": `shreg <= {shreg[W-2:0], shiftin}`.
    - "RIGHT": `shreg <= {shiftin, shreg[W-1:1]}`.
    - The accepted bit that brings the count to `SHIFT_WIDTH` completes the word. The next state is IDLE, or PAR when the parity feature is compiled in.
  - PAR: exists only with the parity feature compiled in. The next accepted bit is the parity bit; the word completes and the next state is IDLE.
- Resync: an accepted bit with `sin_first=1` in SHIFT or PAR discards the partial word and restarts as bit 0, with count = 1. It does not set any flag.
- Word completion, evaluated at the edge that samples the completing bit:
  - If `!q_valid`, or `q_valid && q_ready`: `q` and `q_perr` load the new word and `q_valid` becomes 1.
  - If `q_valid && !q_ready`: the word is dropped, `q` is unchanged and `overflow` becomes 1.
- Handshake: when `q_valid && q_ready` and no word completes, `q_valid` clears at the next edge. `q` keeps its last value.
- The handshake runs independently of `enable`. `enable=0` freezes state, count and shift register only.
- `busy` = state is not IDLE.
- `overflow` is cleared only by `sclr`.
- Count width is `$clog2(SHIFT_WIDTH+1)`. The count never wraps, because it is reset on completion.

## Timing
- Reset values: `q=0`, `q_valid=0`, `q_perr=0`, `overflow=0`, `busy=0`; state IDLE; count 0; shift register 0.
- `sclr` has priority over every other input. `sclr` mid-word discards the partial word and drops any pending `q`.
- Latency: `q_valid` is high in the cycle after the edge that samples the completing bit.
- With back-to-back bits, the minimum spacing between words is `SHIFT_WIDTH` cycles, or `SHIFT_WIDTH+1` with parity.
- Sustained throughput without overflow requires `q_ready` to be high at least once per word time.

## Configuration
- Macro: `SERIAL_WORD_RECEIVER_PARITY_CHECK_EN`.
- Defined:
  - One even-parity bit follows the data bits, via the PAR state.
  - `q_perr` = XOR of all data bits and the parity bit. It is registered together with `q`.
  - The word is delivered even when the parity check fails.
- Undefined:
  - The PAR state is absent.
  - `q_perr` is tied to 0.

## Structure
- Package `serial_word_pkg` holds:
  - the state enum: IDLE, SHIFT, PAR;
  - direction constants `DIR_LEFT` and `DIR_RIGHT`;
  - the helper function for count width.
- One sub-module, `serial_word_shifter`, contains the direction-parameterized shift register and bit counter. The top level contains the FSM, the output register and the flags.

## Test plan
All scenarios use `SHIFT_WIDTH=8`.
- "LEFT", bits 1,0,1,1,0,1,0,0 back-to-back, `sin_first` on the first bit, `q_ready=1` -> `q=8'hB4` with `q_valid` high one cycle after the last bit; `busy` low afterwards.
- "RIGHT", same bits -> `q=8'h2D`.
- `q_ready=0`, two full words 8'hB4 then 8'hFF -> `q` stays 8'hB4, `q_valid=1`, `overflow=1`. Then `q_ready=1` -> `q_valid` clears and `overflow` stays 1 until `sclr`.
- Interruptions:
  - 3 bits, then `sin_first=1` with a fresh word 8'h3C -> `q=8'h3C`.
  - Random `enable`/`sin_valid` gaps -> the same word is received.
  - `sclr` after 5 bits -> all outputs return to reset values.
- Bits before any `sin_first` -> discarded; `busy=0`.
- With the macro: 8'hB4 followed by parity 0 -> `q_perr=0`; followed by parity 1 -> `q_perr=1`. Without the macro: 9 bits sent -> the 9th bit is discarded in IDLE.

Source files
------------

// File: rtl/serial_word_pkg.sv
// Shared types and constants for the serial word receiver.
// State encoding, link bit-order names and the counter width helper.
package serial_word_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        PAR   = 2'd2
    } state_t;

    localparam string DIR_LEFT  = "LEFT";
    localparam string DIR_RIGHT = "RIGHT";

    // Wide enough to hold the full word length, not just its last index.
    function automatic int count_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_word_shifter.sv
// Direction-parameterised serial-in shift register and bit counter.
// word_next is the value the register takes at the coming edge.
module serial_word_shifter
    import serial_word_pkg::*;
#(
    parameter int    SHIFT_WIDTH     = 8,
    parameter string SHIFT_DIRECTION = DIR_LEFT
) (
    input  logic                                  clock,
    input  logic                                  sclr,
    input  logic                                  load,
    input  logic                                  shift,
    input  logic                                  clear,
    input  logic                                  shiftin,
    output logic [SHIFT_WIDTH-1:0]                word_next,
    output logic [count_width(SHIFT_WIDTH)-1:0]   count
);

    localparam int CW = count_width(SHIFT_WIDTH);

    logic [SHIFT_WIDTH-1:0] shreg;
    logic [SHIFT_WIDTH-1:0] shifted;
    logic [SHIFT_WIDTH-1:0] loaded;

    // A fresh word starts from a cleared register so stale bits never leak in.
    generate
        if (SHIFT_DIRECTION == DIR_RIGHT) begin : g_right
            assign shifted = {shiftin, shreg[SHIFT_WIDTH-1:1]};
            assign loaded  = {shiftin, {(SHIFT_WIDTH-1){1'b0}}};
        end else begin : g_left
            assign shifted = {shreg[SHIFT_WIDTH-2:0], shiftin};
            assign loaded  = {{(SHIFT_WIDTH-1){1'b0}}, shiftin};
        end
    endgenerate

    // NOTE: default assignment first so every path drives word_next and no latch is inferred.
    always_comb begin
        word_next = shreg;
        if (load) begin
            word_next = loaded;
        end else if (shift) begin
            word_next = shifted;
        end
    end

    // NOTE: non-blocking assignments for all state so every register samples pre-edge values.
    always_ff @(posedge clock) begin
        if (sclr) begin
            shreg <= '0;
            count <= '0;
        end else begin
            shreg <= word_next;
            if (load) begin
                count <= CW'(1);
            end else if (clear) begin
                count <= '0;
            end else if (shift) begin
                count <= count + CW'(1);
            end
        end
    end

endmodule

// File: rtl/serial_word_receiver.sv
// Serial-to-parallel word receiver with start-marker alignment and valid/ready output.
// Optional even-parity check: define SERIAL_WORD_RECEIVER_PARITY_CHECK_EN.
module serial_word_receiver
    import serial_word_pkg::*;
#(
    parameter int    SHIFT_WIDTH     = 8,
    parameter string SHIFT_DIRECTION = DIR_LEFT
) (
    input  logic                   clock,
    input  logic                   sclr,
    input  logic                   enable,
    input  logic                   sin_valid,
    input  logic                   sin_first,
    input  logic                   shiftin,
    output logic [SHIFT_WIDTH-1:0] q,
    output logic                   q_valid,
    input  logic                   q_ready,
    output logic                   q_perr,
    output logic                   overflow,
    output logic                   busy
);

    localparam int             CW         = count_width(SHIFT_WIDTH);
    localparam logic [CW-1:0]  LAST_COUNT = CW'(SHIFT_WIDTH - 1);

    state_t                 state;
    logic                   accept;
    logic                   start;
    logic                   shift_bit;
    logic                   last_bit;
    logic                   complete;
    logic                   word_perr;
    logic [SHIFT_WIDTH-1:0] word_next;
    logic [CW-1:0]          count;

    assign accept    = enable && sin_valid;
    assign start     = accept && sin_first;
    assign shift_bit = accept && !sin_first && (state == SHIFT);
    assign last_bit  = shift_bit && (count == LAST_COUNT);

`ifdef SERIAL_WORD_RECEIVER_PARITY_CHECK_EN
    // In PAR the register holds, so word_next is the finished data word.
    assign complete  = accept && !sin_first && (state == PAR);
    assign word_perr = (^word_next) ^ shiftin;
`else
    assign complete  = last_bit;
    assign word_perr = 1'b0;
`endif

    assign busy = (state != IDLE);

    serial_word_shifter #(
        .SHIFT_WIDTH     (SHIFT_WIDTH),
        .SHIFT_DIRECTION (SHIFT_DIRECTION)
    ) u_shifter (
        .clock     (clock),
        .sclr      (sclr),
        .load      (start),
        .shift     (shift_bit),
        .clear     (last_bit),
        .shiftin   (shiftin),
        .word_next (word_next),
        .count     (count)
    );

    always_ff @(posedge clock) begin
        if (sclr) begin
            state    <= IDLE;
            q        <= '0;
            q_valid  <= 1'b0;
            q_perr   <= 1'b0;
            overflow <= 1'b0;
        end else begin
            // NOTE: the later assignment wins, so a word landing on a handshake keeps q_valid high.
            if (q_valid && q_ready) begin
                q_valid <= 1'b0;
            end
            if (complete) begin
                if (!q_valid || q_ready) begin
                    q       <= word_next;
                    q_perr  <= word_perr;
                    q_valid <= 1'b1;
                end else begin
                    overflow <= 1'b1;
                end
            end

            if (start) begin
                state <= SHIFT;
            end else if (last_bit) begin
`ifdef SERIAL_WORD_RECEIVER_PARITY_CHECK_EN
                state <= PAR;
`else
                state <= IDLE;
`endif
            end else if (complete) begin
                state <= IDLE;
            end
        end
    end

endmodule

// File: tb/tb_serial_word_receiver.sv
// Directed bench for serial_word_receiver: LEFT and RIGHT instances share one stimulus stream.
// Parity scenarios are selected by SERIAL_WORD_RECEIVER_PARITY_CHECK_EN.
module tb_serial_word_receiver;

    localparam int W = 8;

    logic         clock = 1'b0;
    logic         sclr;
    logic         enable;
    logic         sin_valid;
    logic         sin_first;
    logic         shiftin;
    logic         q_ready;
    logic [W-1:0] q_l, q_r;
    logic         q_valid_l, q_valid_r;
    logic         q_perr_l, q_perr_r;
    logic         overflow_l, overflow_r;
    logic         busy_l, busy_r;

    typedef struct {
        logic [W-1:0] word_l;
        logic [W-1:0] word_r;
        logic         perr;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;

    always #5 clock = ~clock;

    serial_word_receiver #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION("LEFT")) dut_l (
        .clock(clock), .sclr(sclr), .enable(enable), .sin_valid(sin_valid),
        .sin_first(sin_first), .shiftin(shiftin), .q(q_l), .q_valid(q_valid_l),
        .q_ready(q_ready), .q_perr(q_perr_l), .overflow(overflow_l), .busy(busy_l)
    );

    serial_word_receiver #(.SHIFT_WIDTH(W), .SHIFT_DIRECTION("RIGHT")) dut_r (
        .clock(clock), .sclr(sclr), .enable(enable), .sin_valid(sin_valid),
        .sin_first(sin_first), .shiftin(shiftin), .q(q_r), .q_valid(q_valid_r),
        .q_ready(q_ready), .q_perr(q_perr_r), .overflow(overflow_r), .busy(busy_r)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    function automatic logic [W-1:0] reverse(input logic [W-1:0] w);
        logic [W-1:0] r;
        for (int i = 0; i < W; i++) r[i] = w[W-1-i];
        return r;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic send_bit(input logic b, input logic first);
        enable    = 1'b1;
        sin_valid = 1'b1;
        shiftin   = b;
        sin_first = first;
        tick();
        sin_valid = 1'b0;
        sin_first = 1'b0;
        shiftin   = 1'b0;
    endtask

    // Idle cycles that must not be accepted, carrying junk bits and start markers.
    task automatic gaps();
        int n;
        n = $urandom_range(0, 3);
        repeat (n) begin
            if ($urandom_range(0, 1) == 0) begin
                enable    = 1'b0;
                sin_valid = 1'b1;
            end else begin
                enable    = 1'b1;
                sin_valid = 1'b0;
            end
            shiftin   = 1'($urandom_range(0, 1));
            sin_first = 1'b1;
            tick();
        end
        enable    = 1'b1;
        sin_valid = 1'b0;
        sin_first = 1'b0;
    endtask

    task automatic push_exp(input logic [W-1:0] w, input logic perr);
        exp_t e;
        e.word_l = w;
        e.word_r = reverse(w);
        e.perr   = perr;
        sb.push_back(e);
    endtask

    task automatic send_word(input logic [W-1:0] w, input bit gappy, input bit expect_out);
        for (int i = W - 1; i >= 0; i--) begin
            if (gappy) gaps();
            send_bit(w[i], i == W - 1);
        end
`ifdef SERIAL_WORD_RECEIVER_PARITY_CHECK_EN
        if (gappy) gaps();
        send_bit(^w, 1'b0);
`endif
        if (expect_out) push_exp(w, 1'b0);
    endtask

    task automatic check_word(input string tag);
        exp_t e;
        check({tag, "_valid"}, {31'd0, q_valid_l & q_valid_r}, 32'd1);
        check({tag, "_sb_nonempty"}, {31'd0, sb.size() != 0}, 32'd1);
        if (sb.size() != 0) begin
            e = sb.pop_front();
            check({tag, "_q_left"}, {24'd0, q_l}, {24'd0, e.word_l});
            check({tag, "_q_right"}, {24'd0, q_r}, {24'd0, e.word_r});
            check({tag, "_perr"}, {30'd0, q_perr_l, q_perr_r}, {30'd0, e.perr, e.perr});
        end
    endtask

    task automatic check_reset(input string tag);
        check({tag, "_q"}, {16'd0, q_l, q_r}, 32'd0);
        check({tag, "_flags"},
              {24'd0, q_valid_l, q_valid_r, q_perr_l, q_perr_r, overflow_l, overflow_r, busy_l, busy_r},
              32'd0);
    endtask

    initial begin
        logic [W-1:0] w;

        sclr      = 1'b1;
        enable    = 1'b0;
        sin_valid = 1'b0;
        sin_first = 1'b0;
        shiftin   = 1'b0;
        q_ready   = 1'b1;
        repeat (2) tick();
        sclr = 1'b0;
        check_reset("reset");

        // Basic word, with latency and busy observed around the completing bit.
        w = 8'hB4;
        for (int i = W - 1; i >= 1; i--) send_bit(w[i], i == W - 1);
        check("mid_word_busy", {30'd0, busy_l, busy_r}, 32'd3);
        check("mid_word_valid", {30'd0, q_valid_l, q_valid_r}, 32'd0);
        send_bit(w[0], 1'b0);
`ifdef SERIAL_WORD_RECEIVER_PARITY_CHECK_EN
        check("par_wait_busy", {30'd0, busy_l, busy_r}, 32'd3);
        check("par_wait_valid", {30'd0, q_valid_l, q_valid_r}, 32'd0);
        send_bit(1'b0, 1'b0);
`endif
        push_exp(w, 1'b0);
        check_word("b4");
        check("b4_const", {16'd0, q_l, q_r}, {16'd0, 8'hB4, 8'h2D});
        check("b4_idle_after", {30'd0, busy_l, busy_r}, 32'd0);
        tick();
        check("handshake_clear", {30'd0, q_valid_l, q_valid_r}, 32'd0);
        check("handshake_q_kept", {16'd0, q_l, q_r}, {16'd0, 8'hB4, 8'h2D});

        // Overflow: second word dropped while the first is held.
        q_ready = 1'b0;
        send_word(8'hB4, 1'b0, 1'b1);
        check_word("ovf_first");
        check("ovf_none_yet", {30'd0, overflow_l, overflow_r}, 32'd0);
        send_word(8'hFF, 1'b0, 1'b0);
        check("ovf_q_held", {16'd0, q_l, q_r}, {16'd0, 8'hB4, 8'h2D});
        check("ovf_valid_held", {30'd0, q_valid_l, q_valid_r}, 32'd3);
        check("ovf_flag", {30'd0, overflow_l, overflow_r}, 32'd3);
        q_ready = 1'b1;
        tick();
        check("ovf_drain_valid", {30'd0, q_valid_l, q_valid_r}, 32'd0);
        check("ovf_sticky", {30'd0, overflow_l, overflow_r}, 32'd3);
        tick();
        check("ovf_sticky2", {30'd0, overflow_l, overflow_r}, 32'd3);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check_reset("ovf_sclr");

        // Resync after a partial word.
        send_bit(1'b1, 1'b1);
        send_bit(1'b0, 1'b0);
        send_bit(1'b1, 1'b0);
        check("resync_busy", {30'd0, busy_l, busy_r}, 32'd3);
        send_word(8'h3C, 1'b0, 1'b1);
        check_word("resync");
        check("resync_no_ovf", {30'd0, overflow_l, overflow_r}, 32'd0);
        tick();

        // Gated and idle cycles between bits.
        send_word(8'h5A, 1'b1, 1'b1);
        check_word("gaps");
        tick();

        // sclr mid-word also drops a pending output word.
        q_ready = 1'b0;
        send_word(8'h81, 1'b0, 1'b1);
        check_word("pending");
        w = 8'h96;
        for (int i = W - 1; i >= W - 5; i--) send_bit(w[i], i == W - 1);
        check("sclr_mid_busy", {30'd0, busy_l, busy_r}, 32'd3);
        sclr = 1'b1;
        tick();
        sclr = 1'b0;
        check_reset("sclr_mid");
        q_ready = 1'b1;

        // Bits without a start marker are ignored.
        for (int i = 0; i < 5; i++) send_bit(1'b1, 1'b0);
        check("no_first_busy", {30'd0, busy_l, busy_r}, 32'd0);
        check("no_first_valid", {30'd0, q_valid_l, q_valid_r}, 32'd0);

`ifdef SERIAL_WORD_RECEIVER_PARITY_CHECK_EN
        w = 8'hB4;
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], i == W - 1);
        send_bit(1'b0, 1'b0);
        push_exp(w, 1'b0);
        check_word("parity_ok");
        tick();
        for (int i = W - 1; i >= 0; i--) send_bit(w[i], i == W - 1);
        send_bit(1'b1, 1'b0);
        push_exp(w, 1'b1);
        check_word("parity_err");
        tick();
`else
        send_word(8'hC3, 1'b0, 1'b1);
        check_word("nine_word");
        send_bit(1'b1, 1'b0);
        check("ninth_busy", {30'd0, busy_l, busy_r}, 32'd0);
        check("ninth_valid", {30'd0, q_valid_l, q_valid_r}, 32'd0);
        check("ninth_q_kept", {16'd0, q_l, q_r}, {16'd0, 8'hC3, 8'hC3});
`endif

        check("sb_drained", sb.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
